// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the
// RUN/HALTED control machine, with branch redirect, stall hold and halt.
module fetch_stage #(
    parameter int          IMEM_AW   = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e      state_q;
    state_e      state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] pc4_q;
    logic [31:0] pc4_d;
    logic        valid_q;
    logic        valid_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    logic [31:0] pc_plus4;
    logic        is_halt;

    // Mutually exclusive per-cycle actions, in priority order.
    logic        sel_branch;
    logic        sel_hold;
    logic        sel_bubble;
    logic        sel_fetch;

    // PC increment wraps naturally at 2^32.
    assign pc_plus4 = pc_q + 32'd4;
    assign is_halt  = (imem_rdata == HALT_WORD);

    // Resolve the cycle action: branch beats stall beats halt beats fetch.
    always_comb begin
        sel_branch = branch_taken;
        sel_hold   = !branch_taken && stall;
        sel_bubble = !branch_taken && !stall && (state_q == HALTED);
        sel_fetch  = !branch_taken && !stall && (state_q == RUN);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the RUN/HALTED machine.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            sel_branch: state_d = RUN;
            sel_hold:   state_d = state_q;
            sel_bubble: state_d = HALTED;
            sel_fetch:  state_d = is_halt ? HALTED : RUN;
            default:    state_d = state_q;
        endcase
    end

    // Output logic of the machine.
    always_comb begin
        halted = (state_q == HALTED);
    end

    // Next values of the PC, IF/ID register and fetch counter.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            sel_branch: begin
                pc_d    = branch_target;
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
            sel_hold: begin
                pc_d    = pc_q;
            end
            sel_bubble: begin
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
            sel_fetch: begin
                instr_d = imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 32'd1;
                // A halt word is kept but the PC parks on it.
                pc_d    = is_halt ? pc_q : pc_plus4;
            end
            default: begin
                pc_d    = pc_q;
            end
        endcase
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    // Count of valid instructions handed to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, fetch, stall, branch,
// halt, mid-cycle reset and PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0080;
        step();
        step();
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
        end
        checks++;
        if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ifid: got %h/%h/%b want 0/0/0", if_id_instr, if_id_pc4, if_id_valid);
        end
        checks++;
        if (fetch_count !== 32'h0 || halted !== 1'b0 || imem_addr !== 8'h0) begin
            errors++;
            $display("FAIL reset_misc: got cnt=%h halt=%b addr=%h want 0/0/0", fetch_count, halted, imem_addr);
        end
        stall = 1'b0;
        branch_taken = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        step();
        checks++;
        if (if_id_instr !== 32'h0142_3020 || if_id_pc4 !== 32'd4 || if_id_valid !== 1'b1 || pc !== 32'd4) begin
            errors++;
            $display("FAIL fetch1: got i=%h p4=%h v=%b pc=%h want 01423020/4/1/4", if_id_instr, if_id_pc4, if_id_valid, pc);
        end
        step();
        checks++;
        if (if_id_instr !== 32'h21EE_0002 || if_id_pc4 !== 32'd8 || fetch_count !== 32'd2 || pc !== 32'd8) begin
            errors++;
            $display("FAIL fetch2: got i=%h p4=%h cnt=%h pc=%h want 21EE0002/8/2/8", if_id_instr, if_id_pc4, fetch_count, pc);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 32'd8 || if_id_instr !== 32'h21EE_0002 || fetch_count !== 32'd2 || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: got pc=%h i=%h cnt=%h v=%b want 8/21EE0002/2/1", i, pc, if_id_instr, fetch_count, if_id_valid);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (pc !== 32'd12 || if_id_instr !== 32'h1000_0002 || if_id_pc4 !== 32'd12 || fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL stall_resume: got pc=%h i=%h p4=%h cnt=%h want c/10000002/c/3", pc, if_id_instr, if_id_pc4, fetch_count);
        end
    endtask

    task automatic test_branch_over_stall();
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0040;
        step();
        checks++;
        if (pc !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL branch_stall: got pc=%h v=%b i=%h p4=%h cnt=%h want 40/0/0/0/3", pc, if_id_valid, if_id_instr, if_id_pc4, fetch_count);
        end
        stall = 1'b0;
        branch_taken = 1'b0;
        step();
        checks++;
        if (pc !== 32'h44 || if_id_instr !== 32'h1000_0010 || if_id_pc4 !== 32'h44 || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL branch_follow: got pc=%h i=%h p4=%h cnt=%h want 44/10000010/44/4", pc, if_id_instr, if_id_pc4, fetch_count);
        end
    endtask

    task automatic test_halt();
        branch_taken = 1'b1;
        branch_target = 32'h0000_0010;
        step();
        branch_taken = 1'b0;
        step();
        checks++;
        if (if_id_instr !== 32'hFFFF_FFFF || if_id_valid !== 1'b1 || halted !== 1'b1 || pc !== 32'h10 || fetch_count !== 32'd5) begin
            errors++;
            $display("FAIL halt_latch: got i=%h v=%b h=%b pc=%h cnt=%h want ffffffff/1/1/10/5", if_id_instr, if_id_valid, halted, pc, fetch_count);
        end
        step();
        checks++;
        if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc4 !== 32'h0 || pc !== 32'h10 || fetch_count !== 32'd5 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_bubble: got i=%h v=%b p4=%h pc=%h cnt=%h h=%b want 0/0/0/10/5/1", if_id_instr, if_id_valid, if_id_pc4, pc, fetch_count, halted);
        end
    endtask

    task automatic test_async_reset_in_halt();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || fetch_count !== 32'h0 || halted !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got pc=%h cnt=%h h=%b v=%b i=%h p4=%h want all 0", pc, fetch_count, halted, if_id_valid, if_id_instr, if_id_pc4);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_branch_unhalt();
        branch_taken = 1'b1;
        branch_target = 32'h0000_0010;
        step();
        branch_taken = 1'b0;
        step();
        checks++;
        if (halted !== 1'b1 || fetch_count !== 32'd1) begin
            errors++;
            $display("FAIL rehalt: got h=%b cnt=%h want 1/1", halted, fetch_count);
        end
        branch_taken = 1'b1;
        branch_target = 32'h0;
        step();
        branch_taken = 1'b0;
        checks++;
        if (halted !== 1'b0 || pc !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 32'd1) begin
            errors++;
            $display("FAIL unhalt: got h=%b pc=%h v=%b cnt=%h want 0/0/0/1", halted, pc, if_id_valid, fetch_count);
        end
        step();
        checks++;
        if (if_id_instr !== 32'h0142_3020 || pc !== 32'd4 || fetch_count !== 32'd2) begin
            errors++;
            $display("FAIL unhalt_fetch: got i=%h pc=%h cnt=%h want 01423020/4/2", if_id_instr, pc, fetch_count);
        end
    endtask

    task automatic test_low_bits_and_wrap();
        branch_taken = 1'b1;
        branch_target = 32'h0000_0042;
        step();
        checks++;
        if (pc !== 32'h42 || imem_addr !== 8'h10) begin
            errors++;
            $display("FAIL low_bits: got pc=%h addr=%h want 42/10", pc, imem_addr);
        end
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        checks++;
        if (pc !== 32'hFFFF_FFFC || imem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_pre: got pc=%h addr=%h want fffffffc/ff", pc, imem_addr);
        end
        step();
        checks++;
        if (pc !== 32'h0 || imem_addr !== 8'h0 || if_id_pc4 !== 32'h0 || if_id_instr !== 32'h1000_00FF || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: got pc=%h addr=%h p4=%h i=%h v=%b want 0/0/0/100000ff/1", pc, imem_addr, if_id_pc4, if_id_instr, if_id_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h1000_0000 | 32'(i);
        end
        mem[0] = 32'h0142_3020;
        mem[1] = 32'h21EE_0002;
        mem[4] = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        test_reset();
        test_fetch();
        test_stall();
        test_branch_over_stall();
        test_halt();
        test_async_reset_in_halt();
        test_branch_unhalt();
        test_low_bits_and_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter IMEM_AW, default 8: instruction-memory word-address width.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 The module SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF: encoding that halts fetch.
REQ-004 The module SHALL have port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 The module SHALL have port stall, input, 1: hazard hold from decode; freezes the PC and the IF/ID register.
REQ-007 The module SHALL have port branch_taken, input, 1: branch or jump resolved taken this cycle.
REQ-008 The module SHALL have port branch_target, input, 32: byte address of the redirect target.
REQ-009 The module SHALL have port imem_addr, output, IMEM_AW: word address equal to pc[IMEM_AW+1:2], combinational from the PC.
REQ-010 The module SHALL have port imem_rdata, input, 32: instruction word, valid in the same cycle as imem_addr.
REQ-011 The module SHALL have port pc, output, 32: current fetch PC.
REQ-012 The module SHALL have port if_id_instr, output, 32: registered instruction presented to the Control/decode stage.
REQ-013 The module SHALL have port if_id_pc4, output, 32: registered PC+4 of if_id_instr.
REQ-014 The module SHALL have port if_id_valid, output, 1: high when if_id_instr is a real fetched instruction and low for a bubble.
REQ-015 The module SHALL have port halted, output, 1: high while the state machine is in HALTED.
REQ-016 The module SHALL have port fetch_count, output, 32: number of instructions latched into IF/ID with valid set.

Function
REQ-017 The state machine SHALL have exactly two states, RUN and HALTED.
REQ-018 The per-cycle priority SHALL be branch_taken > stall > halted hold > normal fetch.
REQ-019 Normal fetch in RUN: pc <= pc+4; if_id_instr <= imem_rdata; if_id_pc4 <= pc+4; if_id_valid <= 1; fetch_count increments by 1.
REQ-020 On branch_taken, regardless of state or stall: pc <= branch_target; if_id_instr <= 0; if_id_pc4 <= 0; if_id_valid <= 0; state <= RUN; fetch_count is unchanged.
REQ-021 When stall is high and branch_taken is low, pc, all IF/ID outputs, state and fetch_count SHALL hold.
REQ-022 When a normal fetch latches imem_rdata == HALT_WORD, the word SHALL be latched as a valid instruction, fetch_count SHALL increment, pc SHALL NOT advance, and state <= HALTED.
REQ-023 In HALTED with no branch_taken and no stall: pc holds; if_id_instr <= 0, if_id_valid <= 0, if_id_pc4 <= 0 (bubbles); fetch_count holds.
REQ-024 A bubble SHALL be encoded as all-zero, i.e. sll $0,$0,0, which Control decodes as a no-op.
REQ-025 PC arithmetic SHALL be 32-bit modulo 2^32; pc = 32'hFFFF_FFFC advancing SHALL wrap to 0.
REQ-026 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 Bits [1:0] of branch_target SHALL be loaded unmodified; imem_addr ignores them.

Reset
REQ-028 Assertion of rst_n low SHALL immediately, without waiting for a clock edge, force: pc = RESET_PC; if_id_instr = 0; if_id_pc4 = 0; if_id_valid = 0; fetch_count = 0; state = RUN; halted = 0.
REQ-029 Reset asserted mid-stall, mid-branch or in HALTED SHALL override all other inputs.
REQ-030 After rst_n deasserts, the first rising edge SHALL perform a normal fetch from RESET_PC.

Verification
REQ-031 Reset, then memory words 0x01423020 (add) and 0x21EE0002 (addi) at PC 0 and 4 -> after edge 1: if_id_instr = 0x01423020, if_id_pc4 = 4, valid = 1; after edge 2: 0x21EE0002, pc4 = 8, fetch_count = 2.
REQ-032 stall held for 3 cycles at pc = 8 -> pc, if_id_instr and fetch_count unchanged for all 3 cycles; the next cycle resumes with pc = 12.
REQ-033 branch_taken = 1 with branch_target = 0x40 while stall = 1 -> next cycle pc = 0x40, if_id_valid = 0, if_id_instr = 0; the following fetch occurs from 0x40.
REQ-034 HALT_WORD at pc = 0x10 -> if_id_instr = 0xFFFFFFFF with valid = 1 and halted = 1; pc stays at 0x10; subsequent cycles give bubbles; a branch_taken to 0x0 returns the machine to RUN.
REQ-035 rst_n pulsed low between clock edges while in HALTED with fetch_count = 5 -> outputs immediately take the REQ-028 reset values.
REQ-036 PC preloaded via branch to 0xFFFFFFFC -> one fetch later pc = 0, and imem_addr wraps to 0.
